// File: rtl/mem_access_ctrl_if.sv
// Core request/response and word-memory bus bundle for mem_access_ctrl.
// slave is the controller's view; master is the core/memory side driving it.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, mem_ready, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_addr, mem_enable, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, mem_ready, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_addr, mem_enable, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store to word-only stalling memory bridge: lane extract, byte/half RMW, wait timeout.
// Optional MEMCTL_STALL_COUNT_EN adds a saturating stall_count output.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_ctrl_if.slave bus
`ifdef MEMCTL_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
    RMW_READ  = 3'd3,
    RMW_WRITE = 3'd4
  } state_t;

  localparam logic TIMEOUT_EN = (MAX_WAIT != 0);

  state_t      state_r, state_nx_s;
  logic [15:0] addr_r, addr_nx_s;
  logic [1:0]  size_r, size_nx_s;
  logic        uns_r, uns_nx_s;
  logic [31:0] wdata_r, wdata_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, wait_inc_s;
  logic        resp_valid_r, resp_valid_nx_s;
  logic        resp_err_r, resp_err_nx_s;
  logic [31:0] resp_rdata_r, resp_rdata_nx_s;
  logic        timeout_s;
  logic        mem_enable_s, mem_wr_s;

  function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] offs);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = offs[0];
      2'b10:   res = (offs != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] offs, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (offs)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offs[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] offs);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (offs)
        2'b00:   res[7:0]   = data[7:0];
        2'b01:   res[15:8]  = data[7:0];
        2'b10:   res[23:16] = data[7:0];
        default: res[31:24] = data[7:0];
      endcase
    end else if (offs[1]) begin
      res[31:16] = data[15:0];
    end else begin
      res[15:0] = data[15:0];
    end
    return res;
  endfunction

  assign wait_inc_s = cnt_r + CNT_W'(1);
  assign timeout_s  = TIMEOUT_EN && (wait_inc_s == CNT_W'(MAX_WAIT));

  // Next-state, capture and response decode
  always_comb begin
    state_nx_s      = state_r;
    addr_nx_s       = addr_r;
    size_nx_s       = size_r;
    uns_nx_s        = uns_r;
    wdata_nx_s      = wdata_r;
    cnt_nx_s        = cnt_r;
    resp_valid_nx_s = 1'b0;
    resp_err_nx_s   = 1'b0;
    resp_rdata_nx_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          addr_nx_s  = bus.req_addr;
          size_nx_s  = bus.req_size;
          uns_nx_s   = bus.req_unsigned;
          wdata_nx_s = bus.req_wdata;
          cnt_nx_s   = {CNT_W{1'b0}};
          if (size_illegal(bus.req_size, bus.req_addr[1:0])) begin
            resp_valid_nx_s = 1'b1;
            resp_err_nx_s   = 1'b1;
          end else if (!bus.req_wr) begin
            state_nx_s = READ;
          end else if (bus.req_size == 2'b10) begin
            state_nx_s = WRITE;
          end else begin
            state_nx_s = RMW_READ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ, WRITE, RMW_READ, RMW_WRITE: begin
        if (!bus.mem_ready) begin
          if (timeout_s) begin
            state_nx_s      = IDLE;
            resp_valid_nx_s = 1'b1;
            resp_err_nx_s   = 1'b1;
          end else begin
            cnt_nx_s = wait_inc_s;
          end
        end else if (bus.mem_err) begin
          state_nx_s      = IDLE;
          resp_valid_nx_s = 1'b1;
          resp_err_nx_s   = 1'b1;
        end else if (state_r == READ) begin
          state_nx_s      = IDLE;
          resp_valid_nx_s = 1'b1;
          resp_rdata_nx_s = lane_extract(bus.mem_rdata, size_r, addr_r[1:0], uns_r);
        end else if (state_r == RMW_READ) begin
          state_nx_s = RMW_WRITE;
          wdata_nx_s = lane_merge(bus.mem_rdata, wdata_r, size_r, addr_r[1:0]);
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          state_nx_s      = IDLE;
          resp_valid_nx_s = 1'b1;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Captured request, wait counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= 16'h0000;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      cnt_r        <= {CNT_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      addr_r       <= addr_nx_s;
      size_r       <= size_nx_s;
      uns_r        <= uns_nx_s;
      wdata_r      <= wdata_nx_s;
      cnt_r        <= cnt_nx_s;
      resp_valid_r <= resp_valid_nx_s;
      resp_err_r   <= resp_err_nx_s;
      resp_rdata_r <= resp_rdata_nx_s;
    end
  end

  // Memory strobes follow the state register so reset drops them at once
  assign mem_enable_s   = (state_r != IDLE);
  assign mem_wr_s       = (state_r == WRITE) || (state_r == RMW_WRITE);
  assign bus.mem_enable = mem_enable_s;
  assign bus.mem_wr     = mem_wr_s;
  assign bus.mem_wdata  = mem_wr_s ? wdata_r : 32'h0000_0000;
  assign bus.mem_addr   = {addr_r[15:2], 2'b00};
  assign bus.req_ready  = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;

`ifdef MEMCTL_STALL_COUNT_EN
  logic [31:0] stall_count_r;

  // Saturating count of enabled cycles spent waiting on the memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 32'h0000_0000;
    end else if (mem_enable_s && !bus.mem_ready && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl; a second instance with MAX_WAIT=4 covers timeout.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] mem [16];
  logic [32:0] sb_q [$];
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [15:0] last_waddr = 16'h0;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus4 ();

`ifdef MEMCTL_STALL_COUNT_EN
  logic [31:0] stall_count_s;
  logic [31:0] stall_count4_s;
`endif

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
`ifdef MEMCTL_STALL_COUNT_EN
    , .stall_count(stall_count_s)
`endif
  );

  mem_access_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
`ifdef MEMCTL_STALL_COUNT_EN
    , .stall_count(stall_count4_s)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata  = mem[bus.mem_addr[5:2]];
  assign bus4.mem_rdata = 32'h0;

  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr && bus.mem_ready) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.mem_wdata;
      last_waddr <= bus.mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  // One request on the main instance: called at a negedge with the DUT idle.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_en, input int ready_delay);
    int n, en_n, busy_n;
    logic [15:0] a0;
    logic moved, got;
    logic [32:0] exp;
    sb_q.push_back({exp_err, exp_rdata});
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.mem_ready = (ready_delay == 0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1; en_n = 0; busy_n = 0; moved = 1'b0; got = 1'b0; a0 = 16'h0;
    while (n <= 20 && !got) begin
      if (bus.mem_enable) begin
        if (en_n == 0) a0 = bus.mem_addr;
        else if (bus.mem_addr !== a0) moved = 1'b1;
        en_n++;
        bus.mem_ready = (en_n > ready_delay);
      end
      if (bus.busy) busy_n++;
      if (bus.resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_got"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_en"}, en_n, exp_en);
    chk({tag, "_busy"}, busy_n, exp_en);
    chk({tag, "_addr_hold"}, 32'(moved), 32'd0);
    if (got) begin
      exp = sb_q.pop_front();
      chk({tag, "_rdata"}, bus.resp_rdata, exp[31:0]);
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp[32]));
      chk({tag, "_resp_ready"}, 32'(bus.req_ready), 32'd1);
    end else begin
      void'(sb_q.pop_front());
    end
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    int n, en_n, wr0;
    logic idle_ok;
    logic [32:0] exp;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4]  = 32'h80FF_7F01;
    mem[8]  = 32'hDEAD_BEEF;
    mem[12] = 32'h1122_3344;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 16'h0; bus.req_wdata = 32'h0; bus.mem_ready = 1'b1; bus.mem_err = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_wr = 1'b0; bus4.req_size = 2'b00; bus4.req_unsigned = 1'b0;
    bus4.req_addr = 16'h0; bus4.req_wdata = 32'h0; bus4.mem_ready = 1'b0; bus4.mem_err = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("lb_11",  1'b0, 2'b00, 1'b0, 16'h0011, 32'h0, 32'h0000_007F, 1'b0, 2, 1, 0);
    run_req("lbu_13", 1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0);
    run_req("lh_12",  1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1, 0);
    run_req("lhu_10", 1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'h0000_7F01, 1'b0, 2, 1, 0);
    run_req("lw_stall", 1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 7, 6, 5);
`ifdef MEMCTL_STALL_COUNT_EN
    chk("stall_count", stall_count_s, 32'd5);
`endif

    wr0 = wr_cnt;
    run_req("sb_31", 1'b1, 2'b00, 1'b0, 16'h0031, 32'h0000_00AA, 32'h0, 1'b0, 3, 2, 0);
    chk("sb_31_wdata", last_wdata, 32'h1122_AA44);
    chk("sb_31_waddr", 32'(last_waddr), 32'h0000_0030);
    chk("sb_31_wcnt", wr_cnt - wr0, 32'd1);
    run_req("sh_32", 1'b1, 2'b01, 1'b0, 16'h0032, 32'hFFFF_5555, 32'h0, 1'b0, 3, 2, 0);
    chk("sh_32_wdata", last_wdata, 32'h5555_3344);
    run_req("sw_04", 1'b1, 2'b10, 1'b0, 16'h0004, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 0);
    chk("sw_04_wdata", last_wdata, 32'hCAFE_F00D);
    chk("sw_04_waddr", 32'(last_waddr), 32'h0000_0004);

    run_req("lw_02_misal", 1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run_req("sh_05_misal", 1'b1, 2'b01, 1'b0, 16'h0005, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
    run_req("size11", 1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1, 1, 0, 0);

    bus.mem_err = 1'b1;
    run_req("lw_memerr", 1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1, 2, 1, 0);
    wr0 = wr_cnt;
    run_req("sb_memerr", 1'b1, 2'b00, 1'b0, 16'h0030, 32'h0000_0077, 32'h0, 1'b1, 2, 1, 0);
    chk("sb_memerr_nowrite", wr_cnt - wr0, 32'd0);
    bus.mem_err = 1'b0;

    // Timeout on the MAX_WAIT=4 instance with ready stuck low
    sb_q.push_back({1'b1, 32'h0});
    bus4.req_valid = 1'b1; bus4.req_size = 2'b10; bus4.req_addr = 16'h0010;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    n = 1; en_n = 0;
    while (n <= 20 && !bus4.resp_valid) begin
      if (bus4.mem_enable) en_n++;
      @(negedge clk);
      n++;
    end
    chk("to_got", 32'(bus4.resp_valid), 32'd1);
    chk("to_waits", en_n, 32'd4);
    chk("to_enable_drop", 32'(bus4.mem_enable), 32'd0);
    exp = sb_q.pop_front();
    chk("to_err", 32'(bus4.resp_err), 32'(exp[32]));
    chk("to_rdata", bus4.resp_rdata, exp[31:0]);
    @(negedge clk);

    // Reset while parked in RMW_READ
    bus.mem_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'b01; bus.req_addr = 16'h0032;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_wait_enable", 32'(bus.mem_enable), 32'd1);
    chk("rmw_wait_wr", 32'(bus.mem_wr), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_enable", 32'(bus.mem_enable), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid || !bus.req_ready || bus.mem_enable) idle_ok = 1'b0;
      @(negedge clk);
    end
    chk("rst_mid_no_resp", 32'(idle_ok), 32'd1);
`ifdef MEMCTL_STALL_COUNT_EN
    chk("stall_count_rst", stall_count_s, 32'd0);
`endif
    run_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 16'h0030, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits between the core's load/store stage and the stalling 32-bit data memory; drives that memory's enable/wr/addr/data_in and consumes its data_out/ready/err.
- Memory port is word-only: block issues word-aligned addresses and turns byte/halfword accesses into word reads with lane extraction, or word read-modify-write.
- Holds each request stable across an arbitrary number of not-ready cycles, stalls the core via req_ready/busy, returns one registered response per request.

Parameters:
- MAX_WAIT, 64, max consecutive not-ready cycles per memory access before timeout; 0 disables timeout.
- CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_wr  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads when 1, else sign-extend
- req_addr  in  16  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid
- busy  out  1  ~req_ready
- mem_addr  out  16  {addr[15:2],2'b00}
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational)
- mem_ready  in  1  access completed this cycle
- mem_err  in  1  memory alignment error

Behaviour:
- Reset (async, rst_n=0): state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, wait counter 0, captured request registers 0. mem_enable/mem_wr decoded from state, so they drop immediately; an in-flight access is abandoned with no response.
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE.
- IDLE: on accept, capture req fields.
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0: no memory access; next cycle resp_valid=1, resp_err=1; stay IDLE.
  - Load: go to READ.
  - Word store: go to WRITE.
  - Byte/half store: go to RMW_READ.
- READ / RMW_READ: mem_enable=1, mem_wr=0. Stay until mem_ready.
  - READ on ready: select lane (byte = addr[1:0]*8, half = addr[1]*16), extend, register into resp_rdata; resp_valid next cycle; go IDLE.
  - RMW_READ on ready: merge req_wdata byte/half into captured word at the lane; go RMW_WRITE.
- WRITE / RMW_WRITE: mem_enable=1, mem_wr=1, mem_wdata = full word (WRITE) or merged word (RMW_WRITE). On mem_ready: resp_valid next cycle, resp_rdata=0; go IDLE.
- mem_err with mem_ready in any access state: terminate, resp_err=1, resp_rdata=0; an RMW skips its write.
- mem_addr, mem_wdata and mem_wr are held constant while waiting on mem_ready.
- Wait counter: clears on entry to each access state, increments each not-ready cycle. When it reaches MAX_WAIT (MAX_WAIT!=0): abort, resp_err=1, go IDLE.
- Response: resp_valid is a registered one-cycle pulse and coincides with req_ready=1, so back-to-back requests are accepted on the response cycle.
- Latency with ready always 1: accept at cycle N, access at N+1, response at N+2; RMW adds 1 cycle.
- Requests presented while busy are ignored; the core holds them.
- Outside access states: mem_enable=0, mem_wr=0, mem_wdata=0.

Optional Feature:
- Macro MEMCTL_STALL_COUNT_EN.
- Defined: adds output stall_count (32 bits), reset 0, +1 every cycle with mem_enable=1 & mem_ready=0, saturates at all-ones.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Memory word 0x0010 = 0x80FF7F01, ready always 1.
  - lb 0x0011 -> resp_rdata=0x0000007F.
  - lbu 0x0013 -> 0x00000080.
  - lh 0x0012 -> 0xFFFF80FF.
  - Each response at accept+2.
- Ready low for 5 cycles, then high, on lw 0x0020 (mem holds 0xDEADBEEF) -> mem_addr/enable stable for 6 cycles, resp_rdata=0xDEADBEEF, busy for 6 cycles; with macro, stall_count=5.
- sb 0x0031 data 0xAA over mem word 0x11223344 -> RMW_WRITE mem_wdata=0x1122AA44, resp_err=0.
- lw 0x0002 and sh 0x0005 -> no mem_enable, resp_valid+resp_err the next cycle.
- MAX_WAIT=4, ready stuck 0 -> resp_err=1 after 4 waits, mem_enable drops.
- rst_n low mid-RMW_READ -> mem_enable 0 immediately, no resp_valid, req_ready=1 after release.
